// File: rtl/cp0_register_file.sv
// MIPS coprocessor-0 register file: Count/Compare timer, Status, Cause and EPC,
// plus exception/eret redirect generation for the fetch stage.
package cp0_pkg;

  typedef struct packed {
    logic        write_enabled;
    logic [4:0]  write_register;
    logic [2:0]  write_select;
    logic [31:0] write_data;
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic [31:0] exception_address;
    logic        in_delay_slot;
    logic        eret_flush;
  } WBToCP0Data;

  typedef struct packed {
    logic [31:0] exception_address;
  } CP0ToIFData;

  typedef struct packed {
    logic [8:0] zero_hi;
    logic       bev;
    logic [5:0] zero_mid;
    logic [7:0] im;
    logic [5:0] zero_lo;
    logic       exl;
    logic       ie;
  } StatusData;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] zero_hi;
    logic [7:0]  ip;
    logic        zero_mid;
    logic [4:0]  exc_code;
    logic [1:0]  zero_lo;
  } CauseData;

  typedef struct packed {
    logic [31:0] epc;
  } EPCData;

endpackage

module cp0_register_file
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIVIDE     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  WBToCP0Data  wb_to_cp0,
  input  logic [4:0]  read_register,
  input  logic [2:0]  read_select,
  output logic [31:0] read_data,
  input  logic [5:0]  hardware_interrupt,
  output CP0ToIFData  cp0_to_if,
  output logic        flush,
  output logic        interrupt_pending
);

  localparam logic [7:0] ADDR_COUNT   = {5'd9, 3'd0};
  localparam logic [7:0] ADDR_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC     = {5'd14, 3'd0};
  localparam logic       TICK_LAST    = 1'(COUNT_DIVIDE - 1);

  localparam StatusData STATUS_RESET = '{bev: 1'b1, default: '0};

  StatusData   status_q, status_d;
  CauseData    cause_q, cause_d;
  EPCData      epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic take_exc, take_eret, do_write, tick_wrap;

  assign take_exc  = wb_valid & wb_to_cp0.exception_valid;
  assign take_eret = wb_valid & wb_to_cp0.eret_flush & ~wb_to_cp0.exception_valid;
  assign do_write  = wb_valid & wb_to_cp0.write_enabled & ~wb_to_cp0.exception_valid
                   & ~wb_to_cp0.eret_flush;
  assign tick_wrap = (tick_q == TICK_LAST);

  always_comb begin
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    compare_d = compare_q;
    count_d   = tick_wrap ? count_q + 32'd1 : count_q;
    tick_d    = tick_wrap ? 1'b0 : tick_q + 1'b1;

    cause_d.ip[7:2] = {hardware_interrupt[5] | cause_q.ti, hardware_interrupt[4:0]};
    cause_d.ti      = cause_q.ti | (count_q == compare_q);

    // A nested exception (EXL already set) must not clobber the original EPC/BD.
    if (take_exc) begin
      status_d.exl     = 1'b1;
      cause_d.exc_code = wb_to_cp0.exception_code;
      if (!status_q.exl) begin
        epc_d.epc  = wb_to_cp0.in_delay_slot ? wb_to_cp0.exception_address - 32'd4
                                             : wb_to_cp0.exception_address;
        cause_d.bd = wb_to_cp0.in_delay_slot;
      end
    end else if (take_eret) begin
      status_d.exl = 1'b0;
    end else if (do_write) begin
      unique case ({wb_to_cp0.write_register, wb_to_cp0.write_select})
        ADDR_STATUS: begin
          status_d.im  = wb_to_cp0.write_data[15:8];
          status_d.exl = wb_to_cp0.write_data[1];
          status_d.ie  = wb_to_cp0.write_data[0];
        end
        ADDR_CAUSE:   cause_d.ip[1:0] = wb_to_cp0.write_data[9:8];
        ADDR_EPC:     epc_d.epc = wb_to_cp0.write_data;
        ADDR_COUNT: begin
          count_d = wb_to_cp0.write_data;
          tick_d  = 1'b0;
        end
        ADDR_COMPARE: begin
          compare_d  = wb_to_cp0.write_data;
          cause_d.ti = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status_q  <= STATUS_RESET;
      cause_q   <= '0;
      epc_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    read_data = '0;
    case ({read_register, read_select})
      ADDR_COUNT:   read_data = count_q;
      ADDR_COMPARE: read_data = compare_q;
      ADDR_STATUS:  read_data = status_q;
      ADDR_CAUSE:   read_data = cause_q;
      ADDR_EPC:     read_data = epc_q;
      default:      read_data = '0;
    endcase
  end

  // Outputs are gated with reset_n so they read zero while reset is held.
  always_comb begin
    cp0_to_if.exception_address = '0;
    if (reset_n && take_exc)       cp0_to_if.exception_address = EXCEPTION_VECTOR;
    else if (reset_n && take_eret) cp0_to_if.exception_address = epc_q.epc;
  end

  assign flush             = reset_n & (take_exc | take_eret);
  assign interrupt_pending = reset_n & status_q.ie & ~status_q.exl
                           & (|(cause_q.ip & status_q.im));

endmodule

// File: tb/tb_cp0_register_file.sv
// Self-checking bench for cp0_register_file: directed scenarios plus a randomized
// run compared every cycle against a field-level behavioural model.
module tb_cp0_register_file;
  import cp0_pkg::*;

  localparam int          DIV = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clock, reset_n, wb_valid;
  WBToCP0Data  wb;
  logic [4:0]  read_register;
  logic [2:0]  read_select;
  logic [31:0] read_data;
  logic [5:0]  hw;
  CP0ToIFData  to_if;
  logic        flush, interrupt_pending;

  int tests, fails;

  logic [7:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_compare, m_count_base;
  int unsigned m_age;

  cp0_register_file #(.EXCEPTION_VECTOR(VEC), .COUNT_DIVIDE(DIV)) dut (
    .clock(clock), .reset_n(reset_n), .wb_valid(wb_valid), .wb_to_cp0(wb),
    .read_register(read_register), .read_select(read_select), .read_data(read_data),
    .hardware_interrupt(hw), .cp0_to_if(to_if), .flush(flush),
    .interrupt_pending(interrupt_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  // Count is the value loaded last plus elapsed cycles divided by the prescale.
  function automatic logic [31:0] mCount();
    return m_count_base + 32'(m_age / DIV);
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] r, input logic [2:0] s);
    logic [31:0] v;
    v = 32'h0;
    if (s == 3'd0) begin
      case (r)
        5'd9:  v = mCount();
        5'd11: v = m_compare;
        5'd12: v = 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
        5'd13: v = {m_bd, m_ti, 14'h0, m_ip, 1'b0, m_exc, 2'b0};
        5'd14: v = m_epc;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = '0;
    m_epc = '0; m_compare = '0; m_count_base = '0; m_age = 0;
  endtask

  task automatic modelStep();
    logic exc, eret, wr, ti_next;
    if (!reset_n) begin
      modelReset();
      return;
    end
    exc     = wb_valid && wb.exception_valid;
    eret    = wb_valid && wb.eret_flush && !wb.exception_valid;
    wr      = wb_valid && wb.write_enabled && !wb.exception_valid && !wb.eret_flush;
    ti_next = m_ti || (mCount() == m_compare);
    m_ip[7:2] = {hw[5] | m_ti, hw[4:0]};
    m_age++;
    if (exc) begin
      if (!m_exl) begin
        m_epc = wb.in_delay_slot ? wb.exception_address - 32'd4 : wb.exception_address;
        m_bd  = wb.in_delay_slot;
      end
      m_exl = 1;
      m_exc = wb.exception_code;
    end else if (eret) begin
      m_exl = 0;
    end else if (wr && wb.write_select == 3'd0) begin
      case (wb.write_register)
        5'd9:  begin m_count_base = wb.write_data; m_age = 0; end
        5'd11: begin m_compare = wb.write_data; ti_next = 0; end
        5'd12: begin m_im = wb.write_data[15:8]; m_exl = wb.write_data[1]; m_ie = wb.write_data[0]; end
        5'd13: m_ip[1:0] = wb.write_data[9:8];
        5'd14: m_epc = wb.write_data;
        default: ;
      endcase
    end
    m_ti = ti_next;
  endtask

  task automatic checkOutput();
    logic        e_flush, e_pend;
    logic [31:0] e_tgt;
    e_flush = 0; e_pend = 0; e_tgt = '0;
    if (reset_n) begin
      if (wb_valid && wb.exception_valid) begin
        e_flush = 1; e_tgt = VEC;
      end else if (wb_valid && wb.eret_flush) begin
        e_flush = 1; e_tgt = m_epc;
      end
      e_pend = m_ie && !m_exl && ((m_ip & m_im) != 8'h0);
    end
    check("read_data", read_data, mRead(read_register, read_select));
    check("flush", {31'b0, flush}, {31'b0, e_flush});
    check("if_target", to_if.exception_address, e_tgt);
    check("int_pending", {31'b0, interrupt_pending}, {31'b0, e_pend});
  endtask

  task automatic idle();
    wb_valid = 0;
    wb = '0;
  endtask

  task automatic cycle();
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    idle();
    wb_valid = 1; wb.write_enabled = 1; wb.write_register = r; wb.write_data = d;
    cycle();
    idle();
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] lit, input string name);
    read_register = r; read_select = 3'd0;
    @(negedge clock);
    checkOutput();
    check(name, read_data, lit);
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic raise(input logic [31:0] pc, input logic ds, input logic [4:0] code);
    idle();
    wb_valid = 1; wb.exception_valid = 1; wb.exception_address = pc;
    wb.in_delay_slot = ds; wb.exception_code = code;
    @(negedge clock);
    checkOutput();
    check("exc_flush", {31'b0, flush}, 32'd1);
    check("exc_target", to_if.exception_address, 32'hBFC0_0380);
    @(posedge clock);
    modelStep();
    #1;
    idle();
  endtask

  task automatic eretTake(input logic [31:0] tgt);
    idle();
    wb_valid = 1; wb.eret_flush = 1;
    @(negedge clock);
    checkOutput();
    check("eret_flush", {31'b0, flush}, 32'd1);
    check("eret_target", to_if.exception_address, tgt);
    @(posedge clock);
    modelStep();
    #1;
    idle();
  endtask

  task automatic applyRandom();
    logic [4:0] regs [7];
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
    idle();
    wb_valid            = ($urandom_range(0, 3) != 0);
    wb.write_enabled    = 1'($urandom_range(0, 1));
    wb.write_register   = regs[$urandom_range(0, 6)];
    wb.write_select     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    wb.write_data       = $urandom();
    if (wb.write_register == 5'd11 && $urandom_range(0, 1) == 1)
      wb.write_data = mCount() + 32'($urandom_range(0, 8));
    if (wb.write_register == 5'd9 && $urandom_range(0, 1) == 1)
      wb.write_data = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
    wb.exception_valid   = ($urandom_range(0, 15) == 0);
    wb.exception_code    = 5'($urandom());
    wb.exception_address = $urandom();
    wb.in_delay_slot     = 1'($urandom_range(0, 1));
    wb.eret_flush        = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 31) == 0) hw = 6'($urandom());
    read_register = regs[$urandom_range(0, 6)];
    read_select   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    if ($urandom_range(0, 499) == 0) begin
      reset_n = 0;
      modelReset();
    end else begin
      reset_n = 1;
    end
    cycle();
  endtask

  initial begin
    int n;
    tests = 0; fails = 0;
    reset_n = 0; hw = '0; read_register = '0; read_select = '0;
    idle();
    modelReset();
    cycle();
    peek(5'd12, 32'h0040_0000, "reset_status");
    reset_n = 1;

    mtc0(5'd11, 32'hFFFF_FFFF);
    cycle();
    cycle();
    mtc0(5'd14, 32'h8000_1000);
    peek(5'd14, 32'h8000_1000, "epc_rw");
    mtc0(5'd12, 32'hFFFF_FFFF);
    peek(5'd12, 32'h0040_FF03, "status_mask");
    mtc0(5'd12, 32'h0);

    raise(32'h8000_0010, 1'b1, 5'h04);
    peek(5'd14, 32'h8000_000C, "epc_delay_slot");
    peek(5'd13, 32'h8000_0010, "cause_after_exc");
    peek(5'd12, 32'h0040_0002, "status_exl");
    raise(32'h8000_0100, 1'b0, 5'h0C);
    peek(5'd14, 32'h8000_000C, "epc_nested_hold");
    peek(5'd13, 32'h8000_0030, "cause_nested_code");
    eretTake(32'h8000_000C);
    peek(5'd12, 32'h0040_0000, "status_after_eret");
    peek(5'd14, 32'h8000_000C, "epc_after_eret");

    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    n = 0;
    while (!interrupt_pending && n < 40) begin
      cycle();
      n++;
    end
    check("timer_latency", 32'(n), 32'd12);
    peek(5'd13, 32'hC000_8030, "cause_timer");
    mtc0(5'd11, 32'd100);
    cycle();
    check("timer_clear_pending", {31'b0, interrupt_pending}, 32'd0);
    peek(5'd13, 32'h8000_0030, "cause_ti_cleared");

    idle();
    wb_valid = 1; wb.write_enabled = 1; wb.write_register = 5'd12; wb.write_data = 32'h0;
    wb.exception_valid = 1; wb.exception_code = 5'h0A; wb.exception_address = 32'h8000_0200;
    cycle();
    idle();
    peek(5'd12, 32'h0040_8003, "status_exc_beats_mtc0");
    peek(5'd14, 32'h8000_0200, "epc_exc_beats_mtc0");

    wb_valid = 1; wb.write_enabled = 1; wb.write_register = 5'd14; wb.write_data = 32'h1234_5678;
    reset_n = 0;
    modelReset();
    cycle();
    idle();
    peek(5'd14, 32'h0, "epc_reset");
    peek(5'd12, 32'h0040_0000, "status_reset");
    peek(5'd13, 32'h0, "cause_reset");
    peek(5'd9, 32'h0, "count_reset");
    reset_n = 1;

    mtc0(5'd9, 32'hFFFF_FFFF);
    peek(5'd9, 32'hFFFF_FFFF, "count_load");
    cycle();
    peek(5'd9, 32'h0, "count_wrap");

    for (int i = 0; i < 3000; i++) applyRandom();
    reset_n = 1;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp0_register_file.md
CP0_REGISTER_FILE -- requirements
Module: cp0_register_file

Interface
REQ-001 Parameter EXCEPTION_VECTOR, 32'hBFC0_0380, general exception entry address driven to fetch.
REQ-002 Parameter COUNT_DIVIDE, 2, clock cycles per Count increment; legal values are 1 and 2.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 wb_valid  input  1  qualifies wb_to_cp0 this cycle.
REQ-006 wb_to_cp0  input  WBToCP0Data  mtc0, exception, eret and delay-slot info from writeback.
REQ-007 read_register  input  5  mfc0 register number.
REQ-008 read_select  input  3  mfc0 select.
REQ-009 read_data  output  32  mfc0 result.
REQ-010 hardware_interrupt  input  6  external interrupt lines, level-sensitive.
REQ-011 cp0_to_if  output  CP0ToIFData  redirect target for fetch.
REQ-012 flush  output  1  an exception or eret is taken this cycle.
REQ-013 interrupt_pending  output  1  an enabled, unmasked interrupt is pending.

Function
REQ-014 The block SHALL implement Count (9,0), Compare (11,0), Status (12,0), Cause (13,0) and EPC (14,0) using the StatusData, CauseData and EPCData layouts.
REQ-015 read_data SHALL be a combinational mux of the current register values; unmapped register/select pairs read 0; there is no bypass of a same-cycle write.
REQ-016 mtc0 SHALL take effect when wb_valid & write_enabled & ~exception_valid & ~eret_flush; the new value is visible from the next cycle.
REQ-017 Writable fields: Status IM, EXL, IE; Cause IP[1:0]; EPC, Count, Compare all bits; all other fields ignore writes.
REQ-018 Status BEV SHALL read 1 at all times; all zero fields SHALL read 0.
REQ-019 Cause IP[6:2] SHALL register hardware_interrupt[4:0] every cycle; IP[7] SHALL register hardware_interrupt[5] | Cause TI.
REQ-020 Exception (wb_valid & exception_valid): Status EXL <= 1, Cause ExcCode <= exception_code; if EXL was 0, EPC <= exception_address - 4 when in_delay_slot else exception_address, and Cause BD <= in_delay_slot; if EXL was 1, EPC and BD SHALL hold.
REQ-021 Eret (wb_valid & eret_flush & ~exception_valid): Status EXL <= 0; EPC unchanged.
REQ-022 Priority within one cycle: exception > eret > mtc0.
REQ-023 flush SHALL equal wb_valid & (exception_valid | eret_flush), combinationally, in the same cycle.
REQ-024 cp0_to_if.exception_address SHALL be EXCEPTION_VECTOR on exception, the current EPC register value (before any same-cycle update) on eret, and 0 otherwise.
REQ-025 Count SHALL increment by 1 every COUNT_DIVIDE cycles via a tick counter and wrap from 32'hFFFF_FFFF to 0.
REQ-026 An mtc0 to Count SHALL load the written value and restart the tick counter, so the next increment occurs COUNT_DIVIDE cycles later.
REQ-027 Cause TI SHALL be set on the cycle after Count equals Compare, and SHALL hold until cleared.
REQ-028 An mtc0 to Compare SHALL clear TI; a write and a match in the same cycle SHALL leave TI clear.
REQ-029 interrupt_pending SHALL equal Status IE & ~Status EXL & |(Cause IP & Status IM), combinationally from the registers.

Reset
REQ-030 While reset_n is low, the block SHALL asynchronously force: Status = 32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0), Cause = 0, EPC = 0, Count = 0, Compare = 0, and tick counter = 0.
REQ-031 While reset_n is low, outputs SHALL be: flush = 0, interrupt_pending = 0, and cp0_to_if.exception_address = 0.
REQ-032 Reset asserted during an exception or write cycle SHALL discard that update entirely.

Verification
REQ-033 The bench SHALL cover: mtc0 EPC = 32'h8000_1000, then mfc0 EPC -> 32'h8000_1000; mtc0 Status = 32'hFFFF_FFFF -> reads 32'h0040_FF03.
REQ-034 The bench SHALL cover: exception with pc 32'h8000_0010, in_delay_slot = 1, code 5'h04 -> flush = 1, target 32'hBFC0_0380; next cycle EPC = 32'h8000_000C, BD = 1, ExcCode = 4, EXL = 1.
REQ-035 The bench SHALL cover: a second exception at pc 32'h8000_0100 while EXL = 1 -> EPC remains 32'h8000_000C, ExcCode updates.
REQ-036 The bench SHALL cover: eret with EPC = 32'h8000_000C -> flush = 1, target 32'h8000_000C; next cycle EXL = 0.
REQ-037 The bench SHALL cover: Compare = 5, Count = 0, IE = 1, IM[7] = 1 -> TI and interrupt_pending set after Count reaches 5 (about 10 cycles at COUNT_DIVIDE = 2); an mtc0 to Compare clears both.
REQ-038 The bench SHALL cover: exception and mtc0 Status in the same cycle -> the write is ignored and EXL = 1; reset_n pulsed low mid-sequence -> all registers return to their REQ-030 values.
